fsb_bus: RTL and testbench
==========================

Name: fsb_bus

Overview:
- Parametrised successor to the fixed CPU-to-peripheral front-side bus: one master port (CPU data side) fanned out to NSLV memory-mapped slaves.
- Slaves are selected by a base/mask window per slave, with a registered request/acknowledge handshake.
- Unmapped addresses and slaves that never answer complete with an error response instead of hanging the CPU.
- Sits between cpu and the peripheral set (RAM, UART, LEDs, switches, VGA, GPIO) in the top level.

Parameters:
- NSLV, 4, number of slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SLV_BASE, {NSLV{32'h0}}, packed NSLV*ADDR_W base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, {NSLV{32'h0}}, packed NSLV*ADDR_W decode masks; a 1 bit participates in the compare.
- TIMEOUT, 255, cycles in WAIT before an error completion; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m_req  in  1  master request; held until m_ack.
- m_rw  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_W  byte address.
- m_wdata  in  DATA_W  write data.
- m_rdata  out  DATA_W  read data; valid while m_ack=1.
- m_ack  out  1  one-cycle completion pulse.
- m_err  out  1  error qualifier; valid while m_ack=1.
- s_req  out  NSLV  one-hot slave request.
- s_rw  out  1  latched rw.
- s_addr  out  ADDR_W  latched offset, m_addr & ~SLV_MASK[sel].
- s_wdata  out  DATA_W  latched write data.
- s_rdata  in  NSLV*DATA_W  packed slave read data.
- s_ack  in  NSLV  slave acknowledge.
- err_cnt  out  16  saturating count of error completions.

Behaviour:
- Clock and reset: single clock, clk. Reset is rst, synchronous and active-high. Reset has priority over every other event.
- Reset values: state IDLE, all outputs 0, err_cnt 0, timeout counter 0. Asserting rst mid-transaction aborts it: s_req drops at the next edge and no m_ack is produced.
- Decode (combinational): hit[i] = ((m_addr & SLV_MASK[i]) == SLV_BASE[i]). sel = lowest index with hit set. miss = no hit.
- FSM states: IDLE, WAIT, RESP.
- IDLE, m_req=0: stay in IDLE.
- IDLE, m_req=1, hit:
  - Latch sel, rw, offset address and wdata.
  - s_req[sel] <= 1; clear the timeout counter; go to WAIT.
- IDLE, m_req=1, miss: m_err <= 1, m_rdata <= 0, m_ack <= 1; go to RESP. No slave is touched.
- WAIT:
  - s_req[sel] and s_rw, s_addr, s_wdata held stable.
  - s_ack bits other than sel are ignored.
  - Acknowledge on s_ack[sel]:
    - Sampled at the edge: m_rdata <= s_rdata[sel] for reads, 0 for writes.
    - m_ack <= 1, s_req <= 0; go to RESP.
  - No acknowledge: the counter increments.
  - Timeout: the counter reaches TIMEOUT-1 with TIMEOUT != 0 and no ack. Then s_req <= 0, m_err <= 1, m_rdata <= 0, m_ack <= 1; go to RESP.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- RESP: m_ack high for exactly this cycle. Next edge: m_ack, m_err <= 0 and go to IDLE. m_rdata holds its value until the next completion.
- Master rule: m_req must be low in the cycle after m_ack. m_req high in IDLE always starts a new transaction.
- Latency: m_req sampled at edge k. s_req is high from k+1. With a zero-wait slave (s_ack in the first WAIT cycle), m_ack is high in cycle k+2. Minimum request-to-ack is 2 cycles; an unmapped address takes 1 cycle.
- Timeout bound: a silent slave yields m_ack exactly TIMEOUT cycles after s_req rises.
- err_cnt increments on every completion with m_err=1 (miss or timeout) and saturates at 16'hFFFF.
- Counter width: clog2(TIMEOUT+1), minimum 1.
- Bus idles at 0: s_rw, s_addr, s_wdata are driven to 0 outside WAIT.

Decomposition:
- Package fsb_pkg:
  - State encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Err counter width constant (16).
  - clog2 function.
- Sub-module fsb_decode: purely combinational. Inputs are m_addr, SLV_BASE and SLV_MASK. Outputs are the sel index, miss, and the masked offset. It is reused by the future instruction-side bus.
- FSM, latches and counters live in fsb_bus.

Test Plan:
- NSLV=4, slave 1 base 0xF0200000, mask 0xFFFF0000, zero-wait. Read 0xF0200004 with s_rdata[1]=0xDEADBEEF -> s_req=4'b0010 with s_addr=0x4 from k+1; m_ack in cycle k+2, m_rdata=0xDEADBEEF, m_err=0.
- Write 0x12345678 to slave 1 with 3 wait cycles -> s_wdata stable for all 4 WAIT cycles; m_ack 5 cycles after request; m_err=0.
- Access 0x80000000 (unmapped) -> no s_req bit ever set; m_ack and m_err high in cycle k+1; m_rdata=0; err_cnt=1.
- TIMEOUT=8, slave never acks -> s_req high for exactly 8 cycles; then m_ack=1, m_err=1. Repeat with s_ack arriving on the 8th WAIT cycle -> m_err=0.
- Overlapping windows: slave 0 and slave 2 both match 0x00001000 -> only s_req[0] is asserted.
- Reset mid-transaction: rst pulsed in the 2nd WAIT cycle -> next edge s_req=0, m_ack never pulses, err_cnt=0; a following read completes normally.

Source files
------------

// File: rtl/fsb_pkg.sv
// Shared types and constants for the front-side bus: FSM encoding,
// error-counter width and a constant-foldable clog2.
package fsb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fsb_state_e;

  localparam int unsigned ERR_CNT_W = 16;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fsb_decode.sv
// Combinational base/mask address decoder: lowest-index matching window wins.
// Shared with the instruction-side bus, so it carries no clock or state.
module fsb_decode
  import fsb_pkg::*;
#(
  parameter int unsigned               NSLV     = 4,
  parameter int unsigned               ADDR_W   = 32,
  parameter int unsigned               SEL_W    = 2,
  parameter logic [NSLV*ADDR_W-1:0]    SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0]    SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_miss,
  output logic [ADDR_W-1:0] o_offset
);

  always_comb begin
    o_sel    = '0;
    o_miss   = 1'b1;
    o_offset = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (o_miss &&
          ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        o_sel    = SEL_W'(i);
        o_miss   = 1'b0;
        o_offset = i_addr & ~SLV_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/fsb_bus.sv
// CPU data-side front-side bus: one master fanned out to NSLV slaves with a
// registered req/ack handshake, error completion for misses and silent slaves.
module fsb_bus
  import fsb_pkg::*;
#(
  parameter int unsigned               NSLV     = 4,
  parameter int unsigned               ADDR_W   = 32,
  parameter int unsigned               DATA_W   = 32,
  parameter logic [NSLV*ADDR_W-1:0]    SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0]    SLV_MASK = '0,
  parameter int unsigned               TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_req,
  input  logic                   m_rw,
  input  logic [ADDR_W-1:0]      m_addr,
  input  logic [DATA_W-1:0]      m_wdata,
  output logic [DATA_W-1:0]      m_rdata,
  output logic                   m_ack,
  output logic                   m_err,
  output logic [NSLV-1:0]        s_req,
  output logic                   s_rw,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  input  logic [NSLV*DATA_W-1:0] s_rdata,
  input  logic [NSLV-1:0]        s_ack,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int unsigned SEL_W     = (NSLV > 1) ? clog2(NSLV) : 1;
  localparam int unsigned CNT_W_RAW = clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(TO_LAST_I);
  localparam bit                   TO_EN   = (TIMEOUT != 0);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  fsb_state_e             r_state,   w_state_nxt;
  logic [SEL_W-1:0]       r_sel,     w_sel_nxt;
  logic [CNT_W-1:0]       r_cnt,     w_cnt_nxt;
  logic [NSLV-1:0]        r_s_req,   w_s_req_nxt;
  logic                   r_s_rw,    w_s_rw_nxt;
  logic [ADDR_W-1:0]      r_s_addr,  w_s_addr_nxt;
  logic [DATA_W-1:0]      r_s_wdata, w_s_wdata_nxt;
  logic [DATA_W-1:0]      r_m_rdata, w_m_rdata_nxt;
  logic                   r_m_ack,   w_m_ack_nxt;
  logic                   r_m_err,   w_m_err_nxt;
  logic [ERR_CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
  logic                   w_err_inc;

  logic [SEL_W-1:0]       w_dec_sel;
  logic                   w_dec_miss;
  logic [ADDR_W-1:0]      w_dec_off;
  logic [NSLV-1:0]        w_dec_onehot;
  logic                   w_ack_sel;
  logic [DATA_W-1:0]      w_rdata_sel;

  fsb_decode #(
    .NSLV     (NSLV),
    .ADDR_W   (ADDR_W),
    .SEL_W    (SEL_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .i_addr   (m_addr),
    .o_sel    (w_dec_sel),
    .o_miss   (w_dec_miss),
    .o_offset (w_dec_off)
  );

  // Selected-slave ack/rdata mux and one-hot request for the decoded slave.
  always_comb begin
    w_ack_sel    = 1'b0;
    w_rdata_sel  = '0;
    w_dec_onehot = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_ack_sel   = s_ack[i];
        w_rdata_sel = s_rdata[i*DATA_W +: DATA_W];
      end
      if (w_dec_sel == SEL_W'(i)) begin
        w_dec_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_cnt_nxt     = r_cnt;
    w_s_req_nxt   = r_s_req;
    w_s_rw_nxt    = r_s_rw;
    w_s_addr_nxt  = r_s_addr;
    w_s_wdata_nxt = r_s_wdata;
    w_m_rdata_nxt = r_m_rdata;
    w_m_ack_nxt   = 1'b0;
    w_m_err_nxt   = 1'b0;
    w_err_inc     = 1'b0;

    case (r_state)
      IDLE: begin
        if (m_req) begin
          if (w_dec_miss) begin
            w_m_err_nxt   = 1'b1;
            w_m_rdata_nxt = '0;
            w_m_ack_nxt   = 1'b1;
            w_err_inc     = 1'b1;
            w_state_nxt   = RESP;
          end else begin
            w_sel_nxt     = w_dec_sel;
            w_s_req_nxt   = w_dec_onehot;
            w_s_rw_nxt    = m_rw;
            w_s_addr_nxt  = w_dec_off;
            w_s_wdata_nxt = m_wdata;
            w_cnt_nxt     = '0;
            w_state_nxt   = WAIT;
          end
        end
      end

      WAIT: begin
        if (w_ack_sel) begin
          w_m_rdata_nxt = r_s_rw ? '0 : w_rdata_sel;
          w_m_ack_nxt   = 1'b1;
          w_state_nxt   = RESP;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_m_rdata_nxt = '0;
          w_m_err_nxt   = 1'b1;
          w_m_ack_nxt   = 1'b1;
          w_err_inc     = 1'b1;
          w_state_nxt   = RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // Bus returns to idle whenever the transaction leaves WAIT.
        if (w_state_nxt == RESP) begin
          w_s_req_nxt   = '0;
          w_s_rw_nxt    = 1'b0;
          w_s_addr_nxt  = '0;
          w_s_wdata_nxt = '0;
        end
      end

      RESP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_err_cnt_nxt = (w_err_inc && (r_err_cnt != ERR_MAX)) ?
                    r_err_cnt + ERR_CNT_W'(1) : r_err_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_s_req   <= '0;
      r_s_rw    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_rdata <= '0;
      r_m_ack   <= 1'b0;
      r_m_err   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_cnt     <= w_cnt_nxt;
      r_s_req   <= w_s_req_nxt;
      r_s_rw    <= w_s_rw_nxt;
      r_s_addr  <= w_s_addr_nxt;
      r_s_wdata <= w_s_wdata_nxt;
      r_m_rdata <= w_m_rdata_nxt;
      r_m_ack   <= w_m_ack_nxt;
      r_m_err   <= w_m_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign m_rdata = r_m_rdata;
  assign m_ack   = r_m_ack;
  assign m_err   = r_m_err;
  assign s_req   = r_s_req;
  assign s_rw    = r_s_rw;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fsb_bus.sv
// Scoreboard bench for fsb_bus: stimulus pushes expected completions, a
// negedge monitor checks slave-side bus and master completions against them.
module tb_fsb_bus;

  localparam int unsigned NSLV    = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [NSLV*AW-1:0] TB_BASE =
    {32'h1000_0000, 32'h0000_0000, 32'hF020_0000, 32'h0000_1000};
  localparam logic [NSLV*AW-1:0] TB_MASK =
    {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000};

  logic [31:0] base_a [NSLV] = '{32'h0000_1000, 32'hF020_0000, 32'h0000_0000, 32'h1000_0000};
  logic [31:0] mask_a [NSLV] = '{32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             m_req = 1'b0;
  logic             m_rw = 1'b0;
  logic [AW-1:0]    m_addr = '0;
  logic [DW-1:0]    m_wdata = '0;
  logic [DW-1:0]    m_rdata;
  logic             m_ack;
  logic             m_err;
  logic [NSLV-1:0]  s_req;
  logic             s_rw;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NSLV*DW-1:0] s_rdata = '0;
  logic [NSLV-1:0]  s_ack = '0;
  logic [15:0]      err_cnt;

  fsb_bus #(
    .NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_req(s_req), .s_rw(s_rw), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    int          sel;
    bit          rw;
    logic [31:0] off;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          exp_cyc;
    int          req_cycles;
    int          err_cnt;
  } exp_t;

  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          req_cyc  = 0;
  int          err_model = 0;
  int          lat_all  = 0;
  bit          mon_en   = 1'b0;
  bit          noise    = 1'b1;
  logic [31:0] rd_val [NSLV];
  int          wcnt   [NSLV];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave models: selected slave acks after lat_all wait cycles (-1 = never);
  // unselected slaves toggle stray acks that the bus must ignore.
  always @(negedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      s_rdata[i*DW +: DW] = rd_val[i];
      if (s_req[i]) begin
        wcnt[i]++;
        s_ack[i] = (lat_all >= 0) && (wcnt[i] == lat_all + 1);
      end else begin
        wcnt[i] = 0;
        s_ack[i] = noise && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: slave-side bus each cycle, master completion on m_ack.
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_req == '0) begin
        check("bus_idle", {s_rw, s_addr, s_wdata}, 65'd0);
      end else begin
        req_cyc++;
        if (exp_q.size() != 0) begin
          exp_t e;
          logic [NSLV-1:0] oh;
          e  = exp_q[0];
          oh = '0;
          if (e.hit) oh[e.sel] = 1'b1;
          check("s_req", s_req, oh);
          check("s_rw", s_rw, e.rw);
          check("s_addr", s_addr, e.off);
          check("s_wdata", s_wdata, e.wdata);
        end
      end
      if (m_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", m_ack, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("m_err", m_err, e.err);
          check("m_rdata", m_rdata, e.rdata);
          check("ack_cycle", cyc, e.exp_cyc);
          check("s_req_cycles", req_cyc, e.req_cycles);
          check("err_cnt", err_cnt, e.err_cnt);
        end
        req_cyc = 0;
      end
    end
  end

  task automatic model_decode(input logic [31:0] addr, output bit hit, output int sel);
    hit = 1'b0;
    sel = 0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & mask_a[i]) == base_a[i]) begin
        hit = 1'b1;
        sel = i;
      end
    end
  endtask

  // One master transaction; expectation computed from the bus rules.
  task automatic do_txn(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                        input int lat, input logic [31:0] rd_force);
    exp_t e;
    bit   hit;
    int   sel;
    int   lat_c;
    bit   got;
    model_decode(addr, hit, sel);
    for (int i = 0; i < NSLV; i++) rd_val[i] = $urandom;
    if (hit && rd_force != 32'd0) rd_val[sel] = rd_force;
    lat_all = lat;
    e.hit   = hit;
    e.sel   = sel;
    e.rw    = rw;
    e.off   = hit ? (addr & ~mask_a[sel]) : 32'd0;
    e.wdata = wd;
    if (!hit) begin
      e.err = 1'b1; e.rdata = '0; lat_c = 1; e.req_cycles = 0;
    end else if (lat < 0 || lat + 1 > int'(TIMEOUT)) begin
      e.err = 1'b1; e.rdata = '0; lat_c = TIMEOUT + 1; e.req_cycles = TIMEOUT;
    end else begin
      e.err = 1'b0; e.rdata = rw ? 32'd0 : rd_val[sel]; lat_c = lat + 2; e.req_cycles = lat + 1;
    end
    if (e.err && err_model < 65535) err_model++;
    e.err_cnt = err_model;
    e.exp_cyc = cyc + lat_c;
    exp_q.push_back(e);
    m_req = 1'b1; m_rw = rw; m_addr = addr; m_wdata = wd;
    got = 1'b0;
    for (int t = 0; t < int'(TIMEOUT) + 20; t++) begin
      @(negedge clk);
      if (m_ack) begin
        got = 1'b1;
        break;
      end
    end
    m_req = 1'b0; m_rw = 1'b0; m_wdata = '0;
    if (!got) begin
      check("ack_seen", 1'b0, 1'b1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      req_cyc = 0;
    end
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NSLV; i++) begin
      rd_val[i] = '0;
      wcnt[i]   = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_ack", m_ack, 1'b0);
    check("rst_m_err", m_err, 1'b0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_s_req", s_req, 4'd0);
    check("rst_err_cnt", err_cnt, 16'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Zero-wait read, 3-wait write, unmapped, timeout, ack on last cycle, overlap.
    do_txn(32'hF020_0004, 1'b0, 32'h0, 0, 32'hDEAD_BEEF);
    do_txn(32'hF020_0008, 1'b1, 32'h1234_5678, 3, 32'h0);
    do_txn(32'h8000_0000, 1'b0, 32'h0, 0, 32'h0);
    do_txn(32'hF020_0010, 1'b0, 32'h0, -1, 32'h0);
    do_txn(32'hF020_0014, 1'b0, 32'h0, 7, 32'h0);
    do_txn(32'h0000_1000, 1'b0, 32'h0, 0, 32'h0);

    // Reset in the second WAIT cycle aborts without a completion.
    lat_all = -1;
    m_req = 1'b1; m_rw = 1'b0; m_addr = 32'hF020_0020;
    @(negedge clk);
    @(negedge clk);
    check("abort_s_req_before", s_req, 4'b0010);
    rst = 1'b1; m_req = 1'b0;
    @(negedge clk);
    check("abort_s_req_after", s_req, 4'd0);
    check("abort_m_ack", m_ack, 1'b0);
    check("abort_err_cnt", err_cnt, 16'd0);
    rst = 1'b0;
    req_cyc = 0;
    err_model = 0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", m_ack, 1'b0);
    end
    do_txn(32'hF020_0030, 1'b0, 32'h0, 1, 32'h0);

    // Randomized traffic across all windows, misses and latencies.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int          k;
      int          lat;
      k = int'($urandom_range(0, 4));
      if (k == 4) a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
      else        a = base_a[k] | ($urandom & ~mask_a[k]);
      lat = int'($urandom_range(0, 11)) - 1;
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, lat, 32'h0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
